// File: rtl/ram32_arbiter.sv
// ram32_arbiter: shares one RAM32 single-port macro between two requesters.
// Round-robin valid/ready arbitration feeds a registered command stage
// that drives the RAM. An in-order response stage then returns the RAM's
// registered read data to the port that issued the command.
// Optional feature: define RAM32_ARB_LOCK_EN to add req0_lock/req1_lock.
// A locked transfer keeps the grant on one port until that port has an
// unlocked transfer accepted.

module ram32_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              CLK,
  input  logic              RST,

  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [3:0]        req0_we,
  input  logic [DATA_W-1:0] req0_wdata,
`ifdef RAM32_ARB_LOCK_EN
  input  logic              req0_lock,
`endif
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_rdata,

  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [3:0]        req1_we,
  input  logic [DATA_W-1:0] req1_wdata,
`ifdef RAM32_ARB_LOCK_EN
  input  logic              req1_lock,
`endif
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_rdata,

  output logic              ram_en,
  output logic [ADDR_W-1:0] ram_a,
  output logic [3:0]        ram_we,
  output logic [DATA_W-1:0] ram_di,
  input  logic [DATA_W-1:0] ram_do,

  output logic              idle
);

  // Round-robin pointer: the port that had the most recent accepted transfer.
  logic last;

  // Combinational grant for this cycle, at most one high.
  logic grant0;
  logic grant1;
  logic elig0;
  logic elig1;
  logic accept;
  logic winner;

  // Payload of the winning port.
  logic [ADDR_W-1:0] sel_addr;
  logic [3:0]        sel_we;
  logic [DATA_W-1:0] sel_wdata;

  // Pipeline occupancy and owner tags. Owner 0 is port 0 and owner 1 is port 1.
  logic s1_valid;
  logic s1_owner;
  logic s2_valid;
  logic s2_owner;

  // Asserted when a held lock shuts the named port out of arbitration.
  logic block0;
  logic block1;

`ifdef RAM32_ARB_LOCK_EN
  typedef enum logic {
    LOCK_FREE = 1'b0,
    LOCK_HELD = 1'b1
  } lock_state_t;

  lock_state_t lock_state;
  lock_state_t lock_state_next;
  logic        lock_owner;
  logic        lock_owner_next;
  logic        sel_lock;

  assign sel_lock = winner ? req1_lock : req0_lock;

  // Lock state register. Reset always releases any held lock.
  always_ff @(posedge CLK) begin
    if (RST) begin
      lock_state <= LOCK_FREE;
      lock_owner <= 1'b0;
    end else begin
      lock_state <= lock_state_next;
      lock_owner <= lock_owner_next;
    end
  end

  // Lock next-state logic. Every accepted transfer either takes the lock or
  // releases it, based on its own lock bit. While the lock is held, only the
  // owner can be accepted.
  always_comb begin
    lock_state_next = lock_state;
    lock_owner_next = lock_owner;
    if (accept) begin
      if (sel_lock) begin
        lock_state_next = LOCK_HELD;
        lock_owner_next = winner;
      end else begin
        lock_state_next = LOCK_FREE;
      end
    end
  end

  assign block0 = (lock_state == LOCK_HELD) &&  lock_owner;
  assign block1 = (lock_state == LOCK_HELD) && !lock_owner;
`else
  assign block0 = 1'b0;
  assign block1 = 1'b0;
`endif

  assign elig0 = req0_valid && !block0;
  assign elig1 = req1_valid && !block1;

  // Arbiter. A lone eligible port wins. On a tie, the port that did not win
  // last time wins. Nothing is granted while reset is held.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!RST) begin
      if (elig0 && elig1) begin
        grant0 = last;
        grant1 = !last;
      end else begin
        grant0 = elig0;
        grant1 = elig1;
      end
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign accept     = grant0 || grant1;
  assign winner     = grant1;

  assign sel_addr  = winner ? req1_addr  : req0_addr;
  assign sel_we    = winner ? req1_we    : req0_we;
  assign sel_wdata = winner ? req1_wdata : req0_wdata;

  // Priority pointer. It moves only when a transfer is accepted, so an idle
  // cycle does not change who wins the next tie.
  always_ff @(posedge CLK) begin
    if (RST) begin
      last <= 1'b1;
    end else if (accept) begin
      last <= winner;
    end
  end

  // Command stage. It captures the winner's payload and drives the RAM
  // directly. Address and data hold when idle, but the write enables drop so
  // an idle cycle never writes.
  always_ff @(posedge CLK) begin
    if (RST) begin
      s1_valid <= 1'b0;
      s1_owner <= 1'b0;
      ram_a    <= '0;
      ram_we   <= '0;
      ram_di   <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_owner <= winner;
        ram_a    <= sel_addr;
        ram_we   <= sel_we;
        ram_di   <= sel_wdata;
      end else begin
        ram_we   <= '0;
      end
    end
  end

  // Response stage. It follows the command stage by one cycle, lining up
  // with the RAM's registered read data. Reset drops anything in flight.
  always_ff @(posedge CLK) begin
    if (RST) begin
      s2_valid <= 1'b0;
      s2_owner <= 1'b0;
    end else begin
      s2_valid <= s1_valid;
      s2_owner <= s1_owner;
    end
  end

  assign ram_en     = s1_valid;
  assign rsp0_valid = s2_valid && !s2_owner;
  assign rsp1_valid = s2_valid &&  s2_owner;
  assign rsp0_rdata = ram_do;
  assign rsp1_rdata = ram_do;
  assign idle       = !s1_valid && !s2_valid;

endmodule

// File: tb/tb_ram32_arbiter.sv
// tb_ram32_arbiter: drives ram32_arbiter with directed and random traffic.
// A behavioural RAM32 model supplies ram_do. A reference model built from
// word memory plus an expected-response queue predicts every output.
// Define RAM32_ARB_LOCK_EN to also exercise the lock ports.

module tb_ram32_arbiter;

  logic        CLK = 1'b0;
  logic        RST;

  logic        req0_valid;
  logic        req0_ready;
  logic [4:0]  req0_addr;
  logic [3:0]  req0_we;
  logic [31:0] req0_wdata;
  logic        req0_lock;
  logic        rsp0_valid;
  logic [31:0] rsp0_rdata;

  logic        req1_valid;
  logic        req1_ready;
  logic [4:0]  req1_addr;
  logic [3:0]  req1_we;
  logic [31:0] req1_wdata;
  logic        req1_lock;
  logic        rsp1_valid;
  logic [31:0] rsp1_rdata;

  logic        ram_en;
  logic [4:0]  ram_a;
  logic [3:0]  ram_we;
  logic [31:0] ram_di;
  logic [31:0] ram_do;
  logic        idle;

  always #5 CLK = ~CLK;

  ram32_arbiter #(.DATA_W(32), .ADDR_W(5)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_addr  (req0_addr),
    .req0_we    (req0_we),
    .req0_wdata (req0_wdata),
`ifdef RAM32_ARB_LOCK_EN
    .req0_lock  (req0_lock),
`endif
    .rsp0_valid (rsp0_valid),
    .rsp0_rdata (rsp0_rdata),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_addr  (req1_addr),
    .req1_we    (req1_we),
    .req1_wdata (req1_wdata),
`ifdef RAM32_ARB_LOCK_EN
    .req1_lock  (req1_lock),
`endif
    .rsp1_valid (rsp1_valid),
    .rsp1_rdata (rsp1_rdata),
    .ram_en     (ram_en),
    .ram_a      (ram_a),
    .ram_we     (ram_we),
    .ram_di     (ram_di),
    .ram_do     (ram_do),
    .idle       (idle)
  );

  // RAM32 behaviour: registered read of the old word, byte-lane writes.
  logic [31:0] ram_mem [32] = '{default: 32'h0};

  always @(posedge CLK) begin
    if (ram_en) begin
      ram_do <= ram_mem[ram_a];
      for (int i = 0; i < 4; i++)
        if (ram_we[i]) ram_mem[ram_a][8*i +: 8] <= ram_di[8*i +: 8];
    end
  end

  // Reference model state.
  typedef struct {
    int          port;
    logic [4:0]  addr;
    logic [3:0]  we;
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] ref_mem [32] = '{default: 32'h0};
  bit          m_last;
  bit          m_lock_held;
  bit          m_lock_owner;
  int          cyc;
  int          errors;
  int          checks;
  logic        obs_r0;
  logic        obs_r1;
  logic [31:0] last_rsp1;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", tag, actual, expected, cyc);
    end
  endtask

  function automatic logic [31:0] mergeBytes(input logic [31:0] old, input logic [31:0] wdata,
                                             input logic [3:0] we);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++)
      if (we[i]) r[8*i +: 8] = wdata[8*i +: 8];
    return r;
  endfunction

  // Runs one clock cycle with the inputs as currently driven. Outputs are
  // checked at the falling edge, then the model advances over the rising edge.
  task automatic applyStimulus();
    bit   elig0, elig1, e0, e1, lk;
    int   widx;
    exp_t ent;
    @(negedge CLK);
    elig0 = req0_valid && !(m_lock_held &&  m_lock_owner);
    elig1 = req1_valid && !(m_lock_held && !m_lock_owner);
    e0 = 1'b0;
    e1 = 1'b0;
    if (!RST) begin
      if (elig0 && elig1) begin
        if (m_last) e0 = 1'b1;
        else        e1 = 1'b1;
      end else begin
        e0 = elig0;
        e1 = elig1;
      end
    end
    obs_r0 = req0_ready;
    obs_r1 = req1_ready;
    checkOutput("req0_ready", 32'(req0_ready), 32'(e0));
    checkOutput("req1_ready", 32'(req1_ready), 32'(e1));
    checkOutput("idle", 32'(idle), 32'(exp_q.size() == 0));

    widx = -1;
    foreach (exp_q[k]) if (exp_q[k].due == cyc + 1) widx = k;
    checkOutput("ram_en", 32'(ram_en), 32'(widx >= 0));
    if (widx >= 0) begin
      checkOutput("ram_a", 32'(ram_a), 32'(exp_q[widx].addr));
      checkOutput("ram_we", 32'(ram_we), 32'(exp_q[widx].we));
    end else begin
      checkOutput("ram_we_idle", 32'(ram_we), 32'h0);
    end

    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      ent = exp_q.pop_front();
      checkOutput("rsp0_valid", 32'(rsp0_valid), 32'(ent.port == 0));
      checkOutput("rsp1_valid", 32'(rsp1_valid), 32'(ent.port == 1));
      if (ent.port == 0) checkOutput("rsp0_rdata", rsp0_rdata, ent.data);
      else               checkOutput("rsp1_rdata", rsp1_rdata, ent.data);
    end else begin
      checkOutput("rsp0_valid", 32'(rsp0_valid), 32'h0);
      checkOutput("rsp1_valid", 32'(rsp1_valid), 32'h0);
    end
    if (rsp1_valid) last_rsp1 = rsp1_rdata;

    if (RST) begin
      exp_q.delete();
      m_last       = 1'b1;
      m_lock_held  = 1'b0;
      m_lock_owner = 1'b0;
    end else if (e0 || e1) begin
      ent.port = e1 ? 1 : 0;
      ent.addr = e1 ? req1_addr : req0_addr;
      ent.we   = e1 ? req1_we : req0_we;
      ent.data = ref_mem[ent.addr];
      ent.due  = cyc + 2;
      exp_q.push_back(ent);
      ref_mem[ent.addr] = mergeBytes(ref_mem[ent.addr], e1 ? req1_wdata : req0_wdata, ent.we);
      m_last = e1;
      lk = e1 ? req1_lock : req0_lock;
      if (lk) begin
        m_lock_held  = 1'b1;
        m_lock_owner = e1;
      end else begin
        m_lock_held  = 1'b0;
      end
    end
    @(posedge CLK);
    cyc++;
    #1;
  endtask

  // Presents one command on a port and holds it until that port is accepted.
  task automatic issue(input int port, input logic [4:0] addr, input logic [3:0] we,
                       input logic [31:0] wdata, input logic lock);
    int   n;
    logic got;
    n = 0;
    if (port == 0) begin
      req0_valid = 1'b1; req0_addr = addr; req0_we = we; req0_wdata = wdata; req0_lock = lock;
    end else begin
      req1_valid = 1'b1; req1_addr = addr; req1_we = we; req1_wdata = wdata; req1_lock = lock;
    end
    do begin
      applyStimulus();
      got = (port == 0) ? obs_r0 : obs_r1;
      n++;
    end while (!got && n < 20);
    if (!got) checkOutput("accept_timeout", 32'(got), 32'h1);
    if (port == 0) begin req0_valid = 1'b0; req0_lock = 1'b0; end
    else           begin req1_valid = 1'b0; req1_lock = 1'b0; end
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus();
  endtask

  task automatic resetPulse();
    RST = 1'b1;
    applyStimulus();
    applyStimulus();
    RST = 1'b0;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bit pend0, pend1;
    errors = 0; checks = 0; cyc = 0;
    m_last = 1'b1; m_lock_held = 1'b0; m_lock_owner = 1'b0;
    last_rsp1 = 32'h0;
    RST = 1'b1;
    req0_valid = 1'b0; req0_addr = '0; req0_we = '0; req0_wdata = '0; req0_lock = 1'b0;
    req1_valid = 1'b0; req1_addr = '0; req1_we = '0; req1_wdata = '0; req1_lock = 1'b0;
    repeat (2) @(posedge CLK);
    #1;

    $display("[TB] reset state");
    checkOutput("rst_ready0", 32'(req0_ready), 32'h0);
    checkOutput("rst_ready1", 32'(req1_ready), 32'h0);
    checkOutput("rst_ram_en", 32'(ram_en), 32'h0);
    checkOutput("rst_ram_we", 32'(ram_we), 32'h0);
    checkOutput("rst_ram_a", 32'(ram_a), 32'h0);
    checkOutput("rst_ram_di", ram_di, 32'h0);
    checkOutput("rst_idle", 32'(idle), 32'h1);
    checkOutput("rst_rsp0", 32'(rsp0_valid), 32'h0);
    checkOutput("rst_rsp1", 32'(rsp1_valid), 32'h0);
    RST = 1'b0;

    $display("[TB] port 0 read of addr 3");
    issue(0, 5'd3, 4'h0, 32'h0, 1'b0);
    idleCycles(3);

    $display("[TB] port 1 byte write then read");
    issue(1, 5'd7, 4'b0101, 32'hDEADBEEF, 1'b0);
    issue(1, 5'd7, 4'h0, 32'h0, 1'b0);
    idleCycles(3);
    checkOutput("byte_write_read", last_rsp1, 32'h00AD00EF);

    $display("[TB] both ports contend for 6 cycles");
    resetPulse();
    req0_valid = 1'b1; req0_addr = 5'($urandom); req0_we = 4'($urandom); req0_wdata = $urandom;
    req1_valid = 1'b1; req1_addr = 5'($urandom); req1_we = 4'($urandom); req1_wdata = $urandom;
    for (int i = 0; i < 6; i++) begin
      applyStimulus();
      checkOutput("alt_grant0", 32'(obs_r0), 32'(i % 2 == 0));
      checkOutput("alt_grant1", 32'(obs_r1), 32'(i % 2 == 1));
      if (obs_r0) begin req0_addr = 5'($urandom); req0_we = 4'($urandom); req0_wdata = $urandom; end
      if (obs_r1) begin req1_addr = 5'($urandom); req1_we = 4'($urandom); req1_wdata = $urandom; end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    idleCycles(4);

    $display("[TB] port 0 streams reads of 0..31");
    req0_valid = 1'b1; req0_we = 4'h0;
    for (int i = 0; i < 32; i++) begin
      req0_addr = 5'(i);
      applyStimulus();
      checkOutput("stream_ready", 32'(obs_r0), 32'h1);
    end
    req0_valid = 1'b0;
    idleCycles(3);

    $display("[TB] reset while a command is in flight");
    issue(0, 5'd9, 4'h0, 32'h0, 1'b0);
    RST = 1'b1;
    applyStimulus();
    RST = 1'b0;
    applyStimulus();
    idleCycles(2);
    issue(0, 5'd9, 4'h0, 32'h0, 1'b0);
    idleCycles(3);

`ifdef RAM32_ARB_LOCK_EN
    $display("[TB] locked read-modify-write on port 1");
    resetPulse();
    req0_valid = 1'b1; req0_addr = 5'd1; req0_we = 4'h0; req0_lock = 1'b0;
    issue(1, 5'd5, 4'h0, 32'h0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus();
      checkOutput("lock_block", 32'(obs_r0), 32'h0);
    end
    req1_valid = 1'b1; req1_addr = 5'd5; req1_we = 4'hF; req1_wdata = $urandom; req1_lock = 1'b0;
    applyStimulus();
    checkOutput("lock_unlock_acc", 32'(obs_r1), 32'h1);
    checkOutput("lock_block_w", 32'(obs_r0), 32'h0);
    req1_valid = 1'b0;
    applyStimulus();
    checkOutput("lock_release", 32'(obs_r0), 32'h1);
    req0_valid = 1'b0;
    idleCycles(3);
`endif

    $display("[TB] random traffic");
    pend0 = 1'b0; pend1 = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (!pend0 && $urandom_range(0, 99) < 60) begin
        req0_valid = 1'b1; req0_addr = 5'($urandom_range(0, 7));
        req0_we = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
        req0_wdata = $urandom;
`ifdef RAM32_ARB_LOCK_EN
        req0_lock = ($urandom_range(0, 3) == 0);
`endif
        pend0 = 1'b1;
      end
      if (!pend1 && $urandom_range(0, 99) < 60) begin
        req1_valid = 1'b1; req1_addr = 5'($urandom_range(0, 7));
        req1_we = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
        req1_wdata = $urandom;
`ifdef RAM32_ARB_LOCK_EN
        req1_lock = ($urandom_range(0, 3) == 0);
`endif
        pend1 = 1'b1;
      end
      RST = ($urandom_range(0, 99) == 0);
      applyStimulus();
      if (obs_r0) begin pend0 = 1'b0; req0_valid = 1'b0; end
      if (obs_r1) begin pend1 = 1'b0; req1_valid = 1'b0; end
    end
    RST = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_lock = 1'b0; req1_lock = 1'b0;
    idleCycles(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
